// File: rtl/trace_port_tx_if.sv
// Byte handshake between a producer and the trace port transmitter.
// The producer drives transmit/tx_byte and a byte moves on transmit && ready.
interface trace_port_tx_if;
  logic       transmit;
  logic [7:0] tx_byte;
  logic       ready;

  modport master (output transmit, output tx_byte, input ready);
  modport slave  (input transmit, input tx_byte, output ready);
endinterface

// File: rtl/trace_port_tx.sv
// TPIU-style parallel trace port transmitter: serialises bytes LSB-first at 1/2/4 bits per
// traceClk edge, with full syncs after reset and periodically, and halfword syncs when idle.
module trace_port_tx #(
  parameter int unsigned DIV           = 4,
  parameter int unsigned SYNC_INTERVAL = 256,
  parameter int unsigned RESET_SYNCS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            width,
  trace_port_tx_if.slave        tp,
  output logic [3:0]            traceDout,
  output logic                  traceClkOut,
  output logic                  sync_active,
  output logic                  busy
);
  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned CW = 16;
  localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_DATA = PW'(DIV / 2);
  localparam logic [CW-1:0] SYNC_N  = CW'(SYNC_INTERVAL);
  localparam logic [CW-1:0] RSYNC_N = CW'(RESET_SYNCS);

  typedef enum logic [1:0] {IDLE_HALF, DATA, SYNC_FULL} state_t;

  state_t          state, state_n;
  logic [1:0]      seq, seq_n;
  logic [PW-1:0]   phase, phase_n;
  logic [2:0]      beats_left, beats_n;
  logic [2:0]      lanes, lanes_n;
  logic [7:0]      shreg, shreg_n;
  logic            hold_full, hold_full_n;
  logic [7:0]      hold_byte, hold_byte_n;
  logic [CW-1:0]   dcount, dcount_n;
  logic [CW-1:0]   rsync, rsync_n;
  logic            ready_q, ready_n;
  logic [3:0]      dout_n;
  logic            clk_out_n, sync_n, busy_n;
  logic            accept, load;
  logic [7:0]      nxt;

  function automatic logic [2:0] lanes_of(input logic [1:0] w);
    case (w)
      2'b11:   return 3'd4;
      2'b10:   return 3'd2;
      default: return 3'd1;
    endcase
  endfunction

  // Beats remaining after the first one of a byte.
  function automatic logic [2:0] beats_of(input logic [1:0] w);
    case (w)
      2'b11:   return 3'd1;
      2'b10:   return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] l);
    return 4'((5'd1 << l) - 5'd1);
  endfunction

  assign tp.ready = ready_q;
  assign accept   = tp.transmit && ready_q;

  // Next-state: beat timing, byte-boundary arbitration, shifter and holding register.
  always_comb begin
    state_n     = state;
    seq_n       = seq;
    phase_n     = (phase == PH_LAST) ? '0 : phase + PW'(1);
    beats_n     = beats_left;
    lanes_n     = lanes;
    shreg_n     = shreg;
    hold_byte_n = hold_byte;
    dcount_n    = dcount;
    rsync_n     = rsync;
    dout_n      = traceDout;
    clk_out_n   = traceClkOut ^ (phase == '0);
    sync_n      = sync_active;
    busy_n      = busy;
    load        = 1'b0;
    nxt         = 8'h00;

    if (phase == PH_DATA) begin
      if (beats_left != 3'd0) begin
        shreg_n = shreg >> lanes;
        beats_n = beats_left - 3'd1;
        dout_n  = shreg_n[3:0] & lane_mask(lanes);
      end else begin
        // Sync sequences are atomic; arbitration only happens once one completes.
        if (state == SYNC_FULL && seq != 2'd3) begin
          seq_n = seq + 2'd1;
          nxt   = (seq == 2'd2) ? 8'h7F : 8'hFF;
        end else if (state == IDLE_HALF && seq == 2'd0) begin
          seq_n = 2'd1;
          nxt   = 8'h7F;
        end else if (rsync != '0 || dcount == SYNC_N) begin
          state_n  = SYNC_FULL;
          seq_n    = 2'd0;
          nxt      = 8'hFF;
          dcount_n = '0;
          if (rsync != '0) rsync_n = rsync - CW'(1);
        end else if (hold_full) begin
          state_n = DATA;
          seq_n   = 2'd0;
          nxt     = hold_byte;
          load    = 1'b1;
          if (dcount != SYNC_N) dcount_n = dcount + CW'(1);
        end else begin
          state_n = IDLE_HALF;
          seq_n   = 2'd0;
          nxt     = 8'hFF;
        end
        lanes_n = lanes_of(width);
        beats_n = beats_of(width);
        shreg_n = nxt;
        dout_n  = nxt[3:0] & lane_mask(lanes_n);
        sync_n  = (state_n != DATA);
        busy_n  = (state_n == DATA);
      end
    end

    if (accept) hold_byte_n = tp.tx_byte;
    hold_full_n = (hold_full && !load) || accept;
    ready_n     = !hold_full_n;
  end

  // Reset re-arms the post-reset full syncs and drops any byte in flight or held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC_FULL;
      seq         <= 2'd3;
      phase       <= '0;
      beats_left  <= 3'd0;
      lanes       <= 3'd1;
      shreg       <= 8'h00;
      hold_full   <= 1'b0;
      hold_byte   <= 8'h00;
      dcount      <= '0;
      rsync       <= RSYNC_N;
      ready_q     <= 1'b0;
      traceDout   <= 4'h0;
      traceClkOut <= 1'b0;
      sync_active <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      seq         <= seq_n;
      phase       <= phase_n;
      beats_left  <= beats_n;
      lanes       <= lanes_n;
      shreg       <= shreg_n;
      hold_full   <= hold_full_n;
      hold_byte   <= hold_byte_n;
      dcount      <= dcount_n;
      rsync       <= rsync_n;
      ready_q     <= ready_n;
      traceDout   <= dout_n;
      traceClkOut <= clk_out_n;
      sync_active <= sync_n;
      busy        <= busy_n;
    end
  end
endmodule

// File: tb/tb_trace_port_tx.sv
// Bench for trace_port_tx: a trace-port receiver model reframes bytes on traceClkOut edges
// and checks data bytes against a scoreboard queue and sync bytes against the sync schedule.
module tb_trace_port_tx;
  localparam int unsigned DIV = 4;
  localparam int unsigned SI  = 4;
  localparam int unsigned RS  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] width;
  logic [3:0] traceDout;
  logic       traceClkOut, sync_active, busy;

  trace_port_tx_if tp();

  trace_port_tx #(.DIV(DIV), .SYNC_INTERVAL(SI), .RESET_SYNCS(RS)) dut (
    .clk(clk), .rst(rst), .width(width), .tp(tp),
    .traceDout(traceDout), .traceClkOut(traceClkOut),
    .sync_active(sync_active), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Receiver model state
  logic       prev_clk;
  int         gap, toggles, beat_i, beats_need, w_cur, ffs;
  int         unit_idx, dsince, nfull, nhalf, ndata;
  logic       framed, f_sync, f_busy;
  logic [7:0] acc;

  function automatic int wdec(input logic [1:0] w);
    if (w == 2'b11) return 4;
    if (w == 2'b10) return 2;
    return 1;
  endfunction

  task automatic byte_done();
    logic [7:0] exp_b;
    logic       is_full;
    if (f_busy) begin
      check("data_inside_sync", ffs, 0);
      check("sync_overdue", dsince < SI, 1);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("data_byte", acc, exp_b);
      end
      dsince++;
      ndata++;
    end else if (acc == 8'hFF) begin
      ffs++;
      check("ff_run_len", ffs <= 3, 1);
    end else begin
      check("sync_end_7f", acc, 8'h7F);
      check("sync_len", (ffs == 3) || (ffs == 1), 1);
      is_full = (ffs == 3);
      check("sync_kind", is_full, (unit_idx < RS) || (dsince >= SI));
      if (is_full) begin
        dsince = 0;
        nfull++;
      end else begin
        nhalf++;
      end
      unit_idx++;
      ffs = 0;
    end
  endtask

  task automatic take_beat();
    logic [3:0] m;
    logic [7:0] part;
    if (beat_i == 0) begin
      w_cur      = wdec(width);
      beats_need = 8 / w_cur;
      acc        = 8'h00;
      f_sync     = sync_active;
      f_busy     = busy;
      check("flags_onehot", sync_active ^ busy, 1);
    end else begin
      check("flags_const", {sync_active, busy}, {f_sync, f_busy});
    end
    m = (w_cur == 4) ? 4'hF : (w_cur == 2) ? 4'h3 : 4'h1;
    check("unused_lanes_zero", traceDout & ~m, 0);
    part = {4'h0, traceDout & m};
    acc  = acc | (part << (beat_i * w_cur));
    beat_i++;
    if (beat_i == beats_need) begin
      beat_i = 0;
      byte_done();
    end
  endtask

  // Sample the port once per traceClkOut edge, half a clk after it changes.
  always @(negedge clk) begin
    if (rst) begin
      prev_clk = 1'b0; gap = 0; toggles = 0; framed = 1'b0; beat_i = 0; ffs = 0;
      unit_idx = 0; dsince = 0; nfull = 0; nhalf = 0; ndata = 0;
    end else begin
      gap++;
      if (traceClkOut !== prev_clk) begin
        prev_clk = traceClkOut;
        if (toggles > 0) check("clk_half_period", gap, DIV);
        gap = 0;
        toggles++;
        if (!framed && sync_active) framed = 1'b1;
        if (framed) take_beat();
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!tp.ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", tp.ready, 1);
    sb.push_back(b);
    tp.transmit = 1'b1;
    tp.tx_byte  = b;
    @(negedge clk);
    tp.transmit = 1'b0;
    check("ready_drop", tp.ready, 0);
  endtask

  // Width changes land just after a traceClkOut edge, well before the next data update.
  task automatic set_width(input logic [1:0] w);
    @(traceClkOut);
    @(negedge clk);
    #1 width = w;
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    while (!busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(tag, busy, 1);
  endtask

  task automatic busy_len(input string tag, input int exp);
    int cnt = 0;
    wait_busy({tag, "_rise"});
    while (busy && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
    check(tag, cnt, exp);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    logic [7:0] stream [10] = '{8'h01, 8'hFF, 8'h7F, 8'h80, 8'h5A, 8'hFE, 8'h7F, 8'hFF, 8'h00, 8'h3D};
    int t;
    rst = 1'b1; width = 2'b11; tp.transmit = 1'b0; tp.tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dout", traceDout, 0);
    check("rst_clkout", traceClkOut, 0);
    check("rst_ready", tp.ready, 0);
    check("rst_sync", sync_active, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", tp.ready, 1);

    // Idle after reset: two full syncs, then halfword syncs
    t = 0;
    while (unit_idx < 4 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("t1_units_seen", unit_idx >= 4, 1);
    check("t1_full_syncs", nfull, 2);
    check("t1_half_syncs", nhalf, 2);
    check("t1_no_data", ndata, 0);

    // 0xA5 at 4-bit, then at 1-bit
    send(8'hA5);
    busy_len("t2_busy_len", 2 * DIV);
    set_width(2'b01);
    send(8'hA5);
    busy_len("t3_busy_len", 8 * DIV);
    drain("t3_drained");

    // Reset mid-byte with another byte held: both are discarded
    set_width(2'b11);
    send(8'h3C);
    wait_busy("t5_busy");
    send(8'hC3);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_dout", traceDout, 0);
    check("t5_async_clkout", traceClkOut, 0);
    check("t5_async_ready", tp.ready, 0);
    check("t5_async_sync", sync_active, 0);
    check("t5_async_busy", busy, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream: full syncs after bytes 4 and 8
    for (int i = 0; i < 10; i++) send(stream[i]);
    drain("t4_drained");
    check("t4_full_syncs", nfull, RS + 2);
    check("t4_data_count", ndata, 10);

    // Width change mid-byte takes effect on the next byte
    send(8'h96);
    wait_busy("t6_busy");
    set_width(2'b10);
    send(8'h69);
    send(8'hF0);
    drain("t6_drained");
    check("t6_data_count", ndata, 13);

    repeat (20) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
